// File: rtl/count_pkg.sv
// Shared definitions for the counter-lab run-control block: FSM state
// encoding (also driven out on the debug/LED state port) and its width.
package count_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_tick_divider.sv
// Prescaler for count_sequencer. While en is high the internal count
// advances once per clock. When the count equals div, step is asserted
// combinationally for that cycle and the count returns to zero, so one
// step is produced every div+1 enabled cycles. clr forces the count to
// zero and takes priority over en. With en low the count holds, which is
// how a pause keeps the partially elapsed period.
module tick_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt;

    assign step = en && (cnt == div);

    // Prescale count: clear, wrap on terminal value, or hold when not enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Run-control FSM and timebase for the counter-lab up-counters.
// Controls start, stop and pause are plain levels sampled on every rising
// edge, with stop taking precedence over start, and start over pause.
// limit, div and auto_reload are captured only when a run starts, so
// changing them mid-run has no effect until the next start. done is a
// registered one-cycle pulse on every terminal-count step.
module count_sequencer
    import count_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic [DIV_W-1:0] div_q;
    logic             reload_q;
    logic             done_q;

    logic             load;      // capture run settings and zero the counter
    logic             clr_div;   // zero the prescaler
    logic             tick_en;   // prescaler advances this cycle
    logic             tick;      // a counting step happens this cycle
    logic             term;      // counter sits at the captured terminal count

    // The prescaler only runs in RUN with neither pause nor stop sampled.
    assign tick_en = (state_q == S_RUN) && !pause && !stop;
    assign term    = (count_q == limit_q);

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (clr_div),
        .div   (div_q),
        .step  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; stop overrides everything else.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clr_div = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            clr_div = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        load    = 1'b1;
                        clr_div = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (tick && term && !reload_q) begin
                        state_d = S_DONE;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter, captured run settings and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            limit_q  <= '0;
            div_q    <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                count_q <= '0;
            end else if (load) begin
                limit_q  <= limit;
                div_q    <= div;
                reload_q <= auto_reload;
                count_q  <= '0;
            end else if (tick) begin
                if (term) begin
                    done_q <= 1'b1;
                    if (reload_q) begin
                        count_q <= '0;
                    end
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer (WIDTH=2, DIV_W=4).
module tb_count_sequencer;

    localparam int WIDTH = 2;
    localparam int DIV_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [DIV_W-1:0] div = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    count_sequencer #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .limit       (limit),
        .div         (div),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int ec, input int es, input int ed);
        check({tag, " count"}, int'(count), ec);
        check({tag, " state"}, int'(state), es);
        check({tag, " busy"}, int'(busy), (es == 1 || es == 2) ? 1 : 0);
        check({tag, " done"}, int'(done), ed);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit st, input bit sp, input bit pa, input bit rl,
                         input int lim, input int dv);
        start       = st;
        stop        = sp;
        pause       = pa;
        auto_reload = rl;
        limit       = WIDTH'(lim);
        div         = DIV_W'(dv);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Counts elapsed RUN cycles in the current step period and applies the
    // stepping rules directly.
    int m_state, m_count, m_done, m_elapsed, m_limit, m_period, m_reload;

    task automatic model_reset;
        m_state = 0; m_count = 0; m_done = 0; m_elapsed = 0;
        m_limit = 0; m_period = 1; m_reload = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit pa, input bit rl,
                              input int lim, input int dv);
        m_done = 0;
        if (sp) begin
            m_state = 0; m_count = 0; m_elapsed = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_limit = lim; m_period = dv + 1; m_reload = rl;
                m_count = 0; m_elapsed = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (pa) begin
                m_state = 2;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_period) begin
                    m_elapsed = 0;
                    if (m_count == m_limit) begin
                        m_done = 1;
                        if (m_reload != 0) m_count = 0;
                        else m_state = 3;
                    end else begin
                        m_count = (m_count + 1) % (1 << WIDTH);
                    end
                end
            end
        end else begin
            if (!pa) m_state = 1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit st, sp, pa, rl;
        int lim, dv;
        int ec, es, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit sp, bit pa, bit rl, int lim, int dv,
                                int ec, int es, int ed);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.rl = rl; v.lim = lim; v.dv = dv;
        v.ec = ec; v.es = es; v.ed = ed;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();
        check_all("reset", 0, 0, 0);

        // One-shot limit=3 div=0, with mid-run setting changes and a
        // start during RUN, then DONE hold, then start+stop collisions.
        tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 3, 3, 1));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 3, 0, 3, 3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0, 3, 3, 0));
        tbl.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].rl, tbl[i].lim, tbl[i].dv);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].ec, tbl[i].es, tbl[i].ed);
        end

        // Auto-reload limit=2 div=2: count steps every 3 cycles, wraps after 2.
        drive(1, 0, 0, 1, 2, 2);
        tick();
        check_all("reload k0", 0, 1, 0);
        drive(0, 0, 0, 1, 2, 2);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_all($sformatf("reload k%0d", k), (k / 3) % 3, 1, (k % 9 == 0) ? 1 : 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        tick();
        check_all("reload stop", 0, 0, 0);

        // Asynchronous reset in the middle of a run at count=2.
        drive(1, 0, 0, 0, 3, 0);
        tick();
        drive(0, 0, 0, 0, 3, 0);
        tick();
        tick();
        check("pre-reset count", int'(count), 2);
        #2;
        reset = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_all("after reset", 0, 0, 0);

        // Pause with div=3: remaining prescale is kept across the pause.
        drive(1, 0, 0, 0, 3, 3);
        tick();
        check_all("pause k0", 0, 1, 0);
        drive(0, 0, 0, 0, 3, 3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_all($sformatf("pause k%0d", k), (k >= 4) ? 1 : 0, 1, 0);
        end
        drive(0, 0, 1, 0, 3, 3);
        for (int k = 6; k <= 10; k++) begin
            tick();
            check_all($sformatf("paused k%0d", k), 1, 2, 0);
        end
        drive(0, 0, 0, 0, 3, 3);
        for (int k = 11; k <= 18; k++) begin
            tick();
            check_all($sformatf("resume k%0d", k), (k < 14) ? 1 : ((k < 18) ? 2 : 3), 1, 0);
        end
        // Stop while PAUSED.
        drive(0, 0, 1, 0, 3, 3);
        tick();
        check_all("pause again", 3, 2, 0);
        drive(0, 1, 1, 0, 3, 3);
        tick();
        check_all("stop in paused", 0, 0, 0);

        // limit=0 with reload, div=1: done every 2 cycles; mid-run changes ignored.
        drive(1, 0, 0, 1, 0, 1);
        tick();
        check_all("lim0 k0", 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k >= 5 && k <= 7) drive(1, 0, 0, 0, 3, 7);
            else drive(0, 0, 0, 0, 3, 7);
            tick();
            check_all($sformatf("lim0 k%0d", k), 0, 1, (k % 2 == 0) ? 1 : 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        tick();
        check_all("lim0 stop", 0, 0, 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            bit st, sp, pa, rl;
            int lim, dv;
            st  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            pa  = ($urandom_range(0, 6) == 0);
            rl  = $urandom_range(0, 1) != 0;
            lim = $urandom_range(0, 3);
            dv  = $urandom_range(0, 3);
            drive(st, sp, pa, rl, lim, dv);
            tick();
            model_step(st, sp, pa, rl, lim, dv);
            exp_q.push_back(WIDTH'(m_count));
            check($sformatf("rand%0d count", c), int'(count), int'(exp_q.pop_front()));
            check($sformatf("rand%0d state", c), int'(state), m_state);
            check($sformatf("rand%0d done", c), int'(done), m_done);
            check($sformatf("rand%0d busy", c), int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
